// File: rtl/axi4_rr_arbiter_pkg.sv
// axi4_rr_arbiter_pkg: shared FSM encodings, AXI field widths and helpers for the arbiter
package axi4_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACT  = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // {len[7:0], size[2:0], burst[1:0]} on top of the ID
    localparam int CTL_FIXED_W = 13;
    localparam int RESP_W      = 2;

    function automatic int wrap_inc(input int i, input int n);
        return (i == n - 1) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/axi4_rr_arbiter_picker.sv
// rr_picker: round-robin select of the first requester at or after ptr_i, wrapping
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);
    logic [IW-1:0] j;
    logic          found;
    // scan from the pointer so the last-served master has lowest priority
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j     = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end
endmodule

// File: rtl/axi4_rr_arbiter.sv
// axi4_rr_arbiter: N-master to 1-slave AXI4 arbiter with independent round-robin read and write paths
module axi4_rr_arbiter
    import axi4_rr_arbiter_pkg::*;
#(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_M-1:0]                       m_arvalid,
    output logic [NUM_M-1:0]                       m_arready,
    input  logic [NUM_M*ADDR_W-1:0]                m_araddr,
    input  logic [NUM_M*(ID_W+CTL_FIXED_W)-1:0]    m_arctl,
    output logic [NUM_M-1:0]                       m_rvalid,
    input  logic [NUM_M-1:0]                       m_rready,
    output logic [NUM_M-1:0]                       m_rlast,
    output logic [DATA_W-1:0]                      m_rdata,
    output logic [RESP_W+ID_W-1:0]                 m_rresp_rid,
    input  logic [NUM_M-1:0]                       m_awvalid,
    output logic [NUM_M-1:0]                       m_awready,
    input  logic [NUM_M*ADDR_W-1:0]                m_awaddr,
    input  logic [NUM_M*(ID_W+CTL_FIXED_W)-1:0]    m_awctl,
    input  logic [NUM_M-1:0]                       m_wvalid,
    output logic [NUM_M-1:0]                       m_wready,
    input  logic [NUM_M-1:0]                       m_wlast,
    input  logic [NUM_M*DATA_W-1:0]                m_wdata,
    input  logic [NUM_M*DATA_W/8-1:0]              m_wstrb,
    output logic [NUM_M-1:0]                       m_bvalid,
    input  logic [NUM_M-1:0]                       m_bready,
    output logic [RESP_W+ID_W-1:0]                 m_bresp_bid,
    output logic [ADDR_W-1:0]                      s_araddr,
    output logic [ID_W-1:0]                        s_arid,
    output logic [7:0]                             s_arlen,
    output logic [2:0]                             s_arsize,
    output logic [1:0]                             s_arburst,
    output logic                                   s_arvalid,
    input  logic                                   s_arready,
    input  logic [DATA_W-1:0]                      s_rdata,
    input  logic [RESP_W-1:0]                      s_rresp,
    input  logic [ID_W-1:0]                        s_rid,
    input  logic                                   s_rlast,
    input  logic                                   s_rvalid,
    output logic                                   s_rready,
    output logic [ADDR_W-1:0]                      s_awaddr,
    output logic [ID_W-1:0]                        s_awid,
    output logic [7:0]                             s_awlen,
    output logic [2:0]                             s_awsize,
    output logic [1:0]                             s_awburst,
    output logic                                   s_awvalid,
    input  logic                                   s_awready,
    output logic [DATA_W-1:0]                      s_wdata,
    output logic [DATA_W/8-1:0]                    s_wstrb,
    output logic                                   s_wlast,
    output logic                                   s_wvalid,
    input  logic                                   s_wready,
    input  logic [RESP_W-1:0]                      s_bresp,
    input  logic [ID_W-1:0]                        s_bid,
    input  logic                                   s_bvalid,
    output logic                                   s_bready,
    output logic [NUM_M-1:0]                       rd_grant,
    output logic [NUM_M-1:0]                       wr_grant
);
    localparam int IW = $clog2(NUM_M);
    localparam int CW = ID_W + CTL_FIXED_W;

    rd_state_t      rd_state_q, rd_state_d;
    logic [NUM_M-1:0] rd_grant_q, rd_grant_d, rd_pick_gnt;
    logic [IW-1:0]  rd_idx_q, rd_idx_d, rd_ptr_q, rd_ptr_d, rd_pick_idx;
    wr_state_t      wr_state_q, wr_state_d;
    logic [NUM_M-1:0] wr_grant_q, wr_grant_d, wr_pick_gnt;
    logic [IW-1:0]  wr_idx_q, wr_idx_d, wr_ptr_q, wr_ptr_d, wr_pick_idx;
    logic           aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic           rd_ad, rd_dt, wr_act, wr_rsp, aw_open, w_open;

    rr_picker #(.N(NUM_M)) u_rd_pick (.req_i(m_arvalid), .ptr_i(rd_ptr_q), .gnt_o(rd_pick_gnt), .idx_o(rd_pick_idx));
    rr_picker #(.N(NUM_M)) u_wr_pick (.req_i(m_awvalid), .ptr_i(wr_ptr_q), .gnt_o(wr_pick_gnt), .idx_o(wr_pick_idx));

    // state, grants and pointers; reset aborts any transaction with no drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_grant_q <= '0;
            rd_idx_q   <= '0;
            rd_ptr_q   <= '0;
            wr_state_q <= W_IDLE;
            wr_grant_q <= '0;
            wr_idx_q   <= '0;
            wr_ptr_q   <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_grant_q <= rd_grant_d;
            rd_idx_q   <= rd_idx_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_state_q <= wr_state_d;
            wr_grant_q <= wr_grant_d;
            wr_idx_q   <= wr_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    // read FSM: grant on AR request, one AR, hold until the last R beat
    always_comb begin
        rd_state_d = rd_state_q;
        rd_grant_d = rd_grant_q;
        rd_idx_d   = rd_idx_q;
        rd_ptr_d   = rd_ptr_q;
        case (rd_state_q)
            R_IDLE: if (|m_arvalid) begin
                rd_state_d = R_ADDR;
                rd_grant_d = rd_pick_gnt;
                rd_idx_d   = rd_pick_idx;
            end
            R_ADDR: if (s_arvalid && s_arready) rd_state_d = R_DATA;
            R_DATA: if (s_rvalid && s_rready && s_rlast) begin
                rd_state_d = R_IDLE;
                rd_grant_d = '0;
                rd_ptr_d   = IW'(wrap_inc(int'(rd_idx_q), NUM_M));
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // write FSM: grant on AW request, AW and last W tracked independently, hold until B
    always_comb begin
        wr_state_d = wr_state_q;
        wr_grant_d = wr_grant_q;
        wr_idx_d   = wr_idx_q;
        wr_ptr_d   = wr_ptr_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (wr_state_q)
            W_IDLE: if (|m_awvalid) begin
                wr_state_d = W_ACT;
                wr_grant_d = wr_pick_gnt;
                wr_idx_d   = wr_pick_idx;
            end
            W_ACT: begin
                aw_done_d = aw_done_q | (s_awvalid & s_awready);
                w_done_d  = w_done_q | (s_wvalid & s_wready & s_wlast);
                if (aw_done_d && w_done_d) begin
                    wr_state_d = W_RESP;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            W_RESP: if (s_bvalid && s_bready) begin
                wr_state_d = W_IDLE;
                wr_grant_d = '0;
                wr_ptr_d   = IW'(wrap_inc(int'(wr_idx_q), NUM_M));
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign rd_ad   = rd_state_q == R_ADDR;
    assign rd_dt   = rd_state_q == R_DATA;
    assign wr_act  = wr_state_q == W_ACT;
    assign wr_rsp  = wr_state_q == W_RESP;
    assign aw_open = wr_act & ~aw_done_q;
    assign w_open  = wr_act & ~w_done_q;

    assign rd_grant = rd_grant_q;
    assign wr_grant = wr_grant_q;

    assign s_arvalid = rd_ad & m_arvalid[rd_idx_q];
    assign s_araddr  = rd_ad ? m_araddr[rd_idx_q*ADDR_W +: ADDR_W] : '0;
    assign {s_arid, s_arlen, s_arsize, s_arburst} = rd_ad ? m_arctl[rd_idx_q*CW +: CW] : '0;
    assign m_arready = rd_ad ? rd_grant_q & {NUM_M{s_arready}} : '0;

    assign s_rready    = rd_dt & m_rready[rd_idx_q];
    assign m_rvalid    = rd_dt ? rd_grant_q & {NUM_M{s_rvalid}} : '0;
    assign m_rlast     = rd_dt ? rd_grant_q & {NUM_M{s_rlast}} : '0;
    assign m_rdata     = rd_dt ? s_rdata : '0;
    assign m_rresp_rid = rd_dt ? {s_rresp, s_rid} : '0;

    assign s_awvalid = aw_open & m_awvalid[wr_idx_q];
    assign s_awaddr  = wr_act ? m_awaddr[wr_idx_q*ADDR_W +: ADDR_W] : '0;
    assign {s_awid, s_awlen, s_awsize, s_awburst} = wr_act ? m_awctl[wr_idx_q*CW +: CW] : '0;
    assign m_awready = aw_open ? wr_grant_q & {NUM_M{s_awready}} : '0;

    assign s_wvalid = w_open & m_wvalid[wr_idx_q];
    assign s_wdata  = wr_act ? m_wdata[wr_idx_q*DATA_W +: DATA_W] : '0;
    assign s_wstrb  = wr_act ? m_wstrb[wr_idx_q*(DATA_W/8) +: DATA_W/8] : '0;
    assign s_wlast  = wr_act & m_wlast[wr_idx_q];
    assign m_wready = w_open ? wr_grant_q & {NUM_M{s_wready}} : '0;

    assign s_bready    = wr_rsp & m_bready[wr_idx_q];
    assign m_bvalid    = wr_rsp ? wr_grant_q & {NUM_M{s_bvalid}} : '0;
    assign m_bresp_bid = wr_rsp ? {s_bresp, s_bid} : '0;
endmodule
